dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the MEM-stage data-memory interface. The pipeline initiates load/store requests; this block serves them with a fixed, configurable latency and holds the pipeline with `stall` until each access completes.
- Word-addressed synchronous storage of 2^ADDR_W words.
- Drop-in replacement for the zero-wait data memory when multi-cycle memory timing is modelled.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 10, word address width; depth = 2^ADDR_W.
- LATENCY, 2, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- init  input  1  reset, synchronous, active-high.
- mem_read  input  1  load request from MEM stage.
- mem_write  input  1  store request from MEM stage.
- adr  input  ADDR_W  word address.
- wdata  input  DATA_W  store data.
- rdata  output  DATA_W  load data; valid in DONE cycle, held until next load completes.
- ready  output  1  one-cycle completion pulse (state DONE).
- stall  output  1  combinational hold request to pipeline (PC, IF/ID, ID/EX, EX/MEM).
- err  output  1  one-cycle pulse: illegal request (mem_read and mem_write both high).

Behaviour:
- Interface decision: one clock `clk`; reset `init` is synchronous and active-high.
- Reset (init high at an edge):
  - state←IDLE, cnt←0, rdata←0, ready←0, err←0.
  - Storage contents are not cleared.
  - Reset mid-access aborts the access; a pending store is NOT committed.
  - init has priority over all other inputs.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, exactly one of mem_read/mem_write high:
    - Latch op, adr, wdata; cnt←LATENCY-1; →BUSY.
    - stall=1 combinationally in this cycle.
  - IDLE, both high:
    - No access; err=1 next cycle; stay IDLE; stall=0.
  - IDLE, neither high: stay IDLE; stall=0.
  - BUSY, cnt≠0: cnt←cnt-1; stall=1. Request inputs are ignored; the latched copy is used.
  - BUSY, cnt==0: commit at this edge. Store writes mem[adr_l]←wdata_l; load sets rdata←mem[adr_l]. →DONE; stall=1 during this BUSY cycle.
  - DONE: ready=1, stall=0; pipeline advances. Request inputs are ignored (same instruction is still presented); →IDLE unconditionally.
- Timing:
  - Request cycle = C0. ready is high in cycle C0+LATENCY+1, and stall is high in C0..C0+LATENCY.
  - LATENCY=1: accept C0, BUSY C1, DONE C2.
- Combinational relation: stall = (IDLE & (mem_read ^ mem_write)) | BUSY.
- rdata:
  - Updated only on load commit; stores leave rdata unchanged.
  - Load following store to the same address returns the new data (store commits before the load is accepted).
- Back-to-back accesses: a minimum of one IDLE cycle separates DONE from the next acceptance, so the max throughput is one access per LATENCY+2 cycles.
- Address is always in range (full 2^ADDR_W decode); no wrap logic.
- Elaboration: LATENCY outside 1..15 triggers an elaboration-time error via generate check.

Optional Feature:
- Macro DMEM_PARITY_EN.
- Defined:
  - Storage is DATA_W+1 bits per word.
  - Store writes even parity of wdata into the extra bit.
  - Load commit recomputes parity; on mismatch, err pulses in the DONE cycle (rdata still delivered).
  - Adds input `par_inject` (1 bit): when high at store commit, the stored parity bit is inverted.
- Undefined: no parity storage, no `par_inject` port; err is driven only by illegal requests.

Test Plan:
- init=1 for 2 cycles, then idle → rdata=0, ready=0, stall=0, err=0.
- LATENCY=2: mem_write, adr=10'h005, wdata=32'hDEADBEEF in C0 → stall=1 in C0..C2, ready=1 in C3, rdata unchanged. Then mem_read adr=5 in C4 → ready in C7, rdata=32'hDEADBEEF, stall low in C7.
- Request held high through DONE → exactly one access (one ready pulse per request); re-accept only in the following IDLE cycle.
- mem_read=mem_write=1 in IDLE → err=1 next cycle, stall=0, memory and rdata unchanged.
- Store to adr=10'h3FF with data 32'h1; init asserted in the BUSY cycle before commit → a later read of 10'h3FF returns the prior content (not 32'h1); state IDLE after reset.
- DMEM_PARITY_EN: store adr=7 with par_inject=1, then load adr=7 → ready=1 and err=1 in the same DONE cycle. Repeat with par_inject=0 → err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage; holds the pipeline via stall.
// Optional DMEM_PARITY_EN adds a per-word even-parity bit and a par_inject input.
module dmem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              init,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_PARITY_EN
    input  logic              par_inject,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              stall,
    output logic              err
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be within 1..15");
        end
    endgenerate

`ifdef DMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;

    logic [MEM_W-1:0]    mem_q [0:(1<<ADDR_W)-1];
    logic [MEM_W-1:0]    rd_word;
    logic [MEM_W-1:0]    wr_word;
    logic                req_one;
    logic                req_bad;
    logic                commit;

    assign req_one = mem_read ^ mem_write;
    assign req_bad = mem_read & mem_write;
    assign commit  = (state_q == BUSY) && (cnt_q == 4'd0);
    assign rd_word = mem_q[adr_q];

`ifdef DMEM_PARITY_EN
    assign wr_word = {(^wdata_q) ^ par_inject, wdata_q};
`else
    assign wr_word = wdata_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_one) begin
                    op_wr_d = mem_write;
                    adr_d   = adr;
                    wdata_d = wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end else if (req_bad) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    if (!op_wr_q) begin
                        rdata_d = rd_word[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
                        // data plus stored bit must have even weight
                        err_d   = ^rd_word;
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage survives reset; a reset at the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!init && commit && op_wr_q) begin
            mem_q[adr_q] <= wr_word;
        end
    end

    assign stall = ((state_q == IDLE) && req_one) || (state_q == BUSY);
    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a transaction-level model.
// Build with DMEM_PARITY_EN defined to also exercise the parity path.
module tb_dmem_responder;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int L  = 2;
    localparam int P  = L + 2;
`ifdef DMEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          init;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          stall;
    logic          err;
`ifdef DMEM_PARITY_EN
    logic          par_inject;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_mem [int];
    bit            model_bad [int];
    logic [DW-1:0] model_rdata;

    dmem_responder #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .LATENCY(L)
    ) dut (
        .clk       (clk),
        .init      (init),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .adr       (adr),
        .wdata     (wdata),
`ifdef DMEM_PARITY_EN
        .par_inject(par_inject),
`endif
        .rdata     (rdata),
        .ready     (ready),
        .stall     (stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    // One full access: request in C0, busy through C0+L, done in C0+L+1.
    task automatic access(input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit inj);
        logic [DW-1:0] exp_rd;
        bit            exp_err;
        @(posedge clk); #1;
        mem_read  = !wr;
        mem_write = wr;
        adr       = a;
        wdata     = d;
`ifdef DMEM_PARITY_EN
        par_inject = inj;
`endif
        for (int k = 0; k <= L; k++) begin
            @(negedge clk);
            checks++;
            if ({stall, ready, err} !== 3'b100) begin
                failures++;
                $display("FAIL access_busy a=%h k=%0d got stall/ready/err=%b want 100",
                         a, k, {stall, ready, err});
            end
            @(posedge clk); #1;
            mem_read  = 1'($urandom);
            mem_write = 1'($urandom);
            adr       = AW'($urandom);
            wdata     = $urandom;
        end
        if (wr) begin
            model_mem[a] = d;
            model_bad[a] = inj;
            exp_rd  = model_rdata;
            exp_err = 1'b0;
        end else begin
            exp_rd  = model_mem[a];
            exp_err = model_bad[a];
            model_rdata = exp_rd;
        end
        @(negedge clk);
        checks++;
        if ({stall, ready, err} !== {1'b0, 1'b1, exp_err}) begin
            failures++;
            $display("FAIL access_done wr=%0b a=%h got stall/ready/err=%b want 01%0b",
                     wr, a, {stall, ready, err}, exp_err);
        end
        checks++;
        if (rdata !== exp_rd) begin
            failures++;
            $display("FAIL access_rdata wr=%0b a=%h got %h want %h", wr, a, rdata, exp_rd);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
`ifdef DMEM_PARITY_EN
        par_inject = 1'b0;
`endif
    endtask

    task automatic test_reset();
        init      = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        adr       = '0;
        wdata     = '0;
`ifdef DMEM_PARITY_EN
        par_inject = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 init = 1'b0;
        model_rdata = '0;
        @(negedge clk);
        checks++;
        if ({rdata, ready, stall, err} !== {32'h0, 3'b000}) begin
            failures++;
            $display("FAIL reset got rdata=%h ready=%b stall=%b err=%b want 0",
                     rdata, ready, stall, err);
        end
    endtask

    task automatic test_store_load();
        access(1'b1, 10'h005, 32'hDEADBEEF, 1'b0);
        access(1'b0, 10'h005, 32'h0, 1'b0);
    endtask

    // Request held high: period L+2 with one ready pulse per period.
    task automatic test_back_to_back();
        int pulses = 0;
        @(posedge clk); #1;
        mem_read = 1'b1;
        adr      = 10'h005;
        for (int c = 0; c < 2 * P; c++) begin
            @(negedge clk);
            if (ready) pulses++;
            checks++;
            if ({stall, ready} !== {(c % P) <= L, (c % P) == L + 1}) begin
                failures++;
                $display("FAIL b2b c=%0d got stall/ready=%b%b want %b%b", c, stall, ready,
                         (c % P) <= L, (c % P) == L + 1);
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0;
        model_rdata = model_mem[5];
        checks++;
        if (pulses != 2 || rdata !== model_rdata) begin
            failures++;
            $display("FAIL b2b_count got pulses=%0d rdata=%h want 2 %h",
                     pulses, rdata, model_rdata);
        end
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        adr       = 10'h005;
        wdata     = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({stall, ready, err} !== 3'b000) begin
            failures++;
            $display("FAIL illegal_c0 got stall/ready/err=%b want 000", {stall, ready, err});
        end
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, ready, err} !== 3'b001 || rdata !== model_rdata) begin
            failures++;
            $display("FAIL illegal_err got stall/ready/err=%b rdata=%h want 001 %h",
                     {stall, ready, err}, rdata, model_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear got err=%b want 0", err);
        end
        access(1'b0, 10'h005, 32'h0, 1'b0);
    endtask

    task automatic test_reset_abort();
        access(1'b1, 10'h3FF, 32'hA5A5_0F0F, 1'b0);
        @(posedge clk); #1;
        mem_write = 1'b1;
        adr       = 10'h3FF;
        wdata     = 32'h1;
        for (int k = 1; k <= L; k++) begin
            @(posedge clk); #1;
            mem_write = 1'b0;
            if (k == L) init = 1'b1;
        end
        @(posedge clk); #1;
        init = 1'b0;
        model_rdata = '0;
        @(negedge clk);
        checks++;
        if ({stall, ready, err} !== 3'b000 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL abort_state got stall/ready/err=%b rdata=%h want 000 0",
                     {stall, ready, err}, rdata);
        end
        access(1'b0, 10'h3FF, 32'h0, 1'b0);
    endtask

    task automatic test_parity();
        if (PAR) begin
            access(1'b1, 10'h007, $urandom, 1'b1);
            access(1'b0, 10'h007, 32'h0, 1'b0);
            access(1'b1, 10'h007, $urandom, 1'b0);
            access(1'b0, 10'h007, 32'h0, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        bit            wr;
        bit            inj;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 10'h005;
                1:       a = 10'h007;
                2:       a = 10'h3FF;
                default: a = AW'($urandom);
            endcase
            wr  = 1'($urandom) || !model_mem.exists(int'(a));
            inj = PAR && wr && 1'($urandom);
            access(wr, a, $urandom, inj);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_illegal();
        test_reset_abort();
        test_parity();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
